// File: rtl/syn_mac_acc.sv
// syn_mac_acc: programmable synaptic accumulator for a single SNN neuron.
// Holds a runtime-loadable table of (source address, signed weight) entries and
// latches incoming spikes by source address. At each timestep boundary it
// serially sums the weights of the connections that spiked, one entry per cycle.
// It then presents the sum on mult_output together with a one-cycle done pulse.
// Optional feature: define SYN_MAC_SATURATE_EN to make every addition clamp to
// the signed ACC_W range and report the clamp on sat. Without it, additions wrap.
module syn_mac_acc #(
    parameter int NUM_CONN = 8,
    parameter int ADDR_W   = 12,
    parameter int WEIGHT_W = 16,
    parameter int ACC_W    = 20,
    parameter int IDX_W    = $clog2(NUM_CONN)
) (
    input  logic                CLK_Mac,
    input  logic                RST_n,
    input  logic                cfg_we,
    input  logic [IDX_W-1:0]    cfg_idx,
    input  logic [ADDR_W-1:0]   cfg_addr,
    input  logic [WEIGHT_W-1:0] cfg_weight,
    input  logic                spike_valid,
    input  logic [ADDR_W-1:0]   spike_addr,
    input  logic                timestep,
    output logic [ACC_W-1:0]    mult_output,
    output logic                done,
    output logic                busy,
    output logic                overrun,
    output logic                sat
);

    typedef enum logic {S_IDLE, S_ACCUM} state_t;

    state_t state_q, state_d;

    logic [NUM_CONN-1:0]        tbl_valid_q, tbl_valid_d;
    logic [ADDR_W-1:0]          tbl_addr_q   [NUM_CONN];
    logic [ADDR_W-1:0]          tbl_addr_d   [NUM_CONN];
    logic signed [WEIGHT_W-1:0] tbl_weight_q [NUM_CONN];
    logic signed [WEIGHT_W-1:0] tbl_weight_d [NUM_CONN];

    logic [NUM_CONN-1:0]        incoming_q, incoming_d;
    logic [NUM_CONN-1:0]        spikes_q, spikes_d;

    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [ACC_W-1:0]           mult_output_q, mult_output_d;
    logic                       done_q, done_d;
    logic                       busy_q, busy_d;
    logic                       overrun_q, overrun_d;

    logic                       cfg_idx_ok;
    logic                       table_wr;
    logic                       ts_accept;
    logic signed [ACC_W-1:0]    term;
    logic signed [ACC_W-1:0]    add_res;

`ifdef SYN_MAC_SATURATE_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W:0]      sum_wide;
    logic                       add_ovf;
    logic                       sat_q, sat_d;
    logic                       sat_flag_q, sat_flag_d;
`endif

    // Indices beyond the table size are dropped; writes land only while idle.
    always_comb begin
        cfg_idx_ok = ({1'b0, cfg_idx} < (IDX_W+1)'(NUM_CONN));
        table_wr   = cfg_we && cfg_idx_ok && (state_q == S_IDLE);
        ts_accept  = timestep && (state_q == S_IDLE);
    end

    // One adder step: the current entry's weight, sign-extended, if it spiked.
    always_comb begin
        term = '0;
        if (spikes_q[idx_q]) begin
            term = ACC_W'(tbl_weight_q[idx_q]);
        end
`ifdef SYN_MAC_SATURATE_EN
        sum_wide = (ACC_W+1)'(acc_q) + (ACC_W+1)'(term);
        add_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
        if (add_ovf) begin
            add_res = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            add_res = sum_wide[ACC_W-1:0];
        end
`else
        add_res = acc_q + term;
`endif
    end

    // Table writes and spike capture; a timestep hands the captured set to the FSM and clears it.
    always_comb begin
        tbl_valid_d  = tbl_valid_q;
        tbl_addr_d   = tbl_addr_q;
        tbl_weight_d = tbl_weight_q;
        incoming_d   = incoming_q;
        if (ts_accept) begin
            incoming_d = '0;
        end
        for (int i = 0; i < NUM_CONN; i++) begin
            if (spike_valid && tbl_valid_q[i] && (tbl_addr_q[i] == spike_addr)) begin
                incoming_d[i] = 1'b1;
            end
        end
        if (table_wr) begin
            tbl_valid_d[cfg_idx]  = 1'b1;
            tbl_addr_d[cfg_idx]   = cfg_addr;
            tbl_weight_d[cfg_idx] = cfg_weight;
            incoming_d[cfg_idx]   = 1'b0;
        end
    end

    // Two-state accumulation FSM; the walk always visits every entry, so latency is fixed.
    always_comb begin
        state_d       = state_q;
        spikes_d      = spikes_q;
        acc_d         = acc_q;
        idx_d         = idx_q;
        mult_output_d = mult_output_q;
        done_d        = 1'b0;
        busy_d        = busy_q;
        overrun_d     = 1'b0;
`ifdef SYN_MAC_SATURATE_EN
        sat_d         = 1'b0;
        sat_flag_d    = sat_flag_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (timestep) begin
                    spikes_d   = incoming_q;
                    acc_d      = '0;
                    idx_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = S_ACCUM;
`ifdef SYN_MAC_SATURATE_EN
                    sat_flag_d = 1'b0;
`endif
                end
            end
            S_ACCUM: begin
                overrun_d = timestep;
                acc_d     = add_res;
`ifdef SYN_MAC_SATURATE_EN
                sat_flag_d = sat_flag_q | add_ovf;
`endif
                if (idx_q == IDX_W'(NUM_CONN - 1)) begin
                    mult_output_d = add_res;
                    done_d        = 1'b1;
                    busy_d        = 1'b0;
                    idx_d         = '0;
                    state_d       = S_IDLE;
`ifdef SYN_MAC_SATURATE_EN
                    sat_d         = sat_flag_q | add_ovf;
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers; reset aborts any timestep and empties the table.
    always_ff @(posedge CLK_Mac or negedge RST_n) begin
        if (!RST_n) begin
            state_q       <= S_IDLE;
            tbl_valid_q   <= '0;
            for (int i = 0; i < NUM_CONN; i++) begin
                tbl_addr_q[i]   <= '0;
                tbl_weight_q[i] <= '0;
            end
            incoming_q    <= '0;
            spikes_q      <= '0;
            acc_q         <= '0;
            idx_q         <= '0;
            mult_output_q <= '0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
`ifdef SYN_MAC_SATURATE_EN
            sat_q         <= 1'b0;
            sat_flag_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            tbl_valid_q   <= tbl_valid_d;
            tbl_addr_q    <= tbl_addr_d;
            tbl_weight_q  <= tbl_weight_d;
            incoming_q    <= incoming_d;
            spikes_q      <= spikes_d;
            acc_q         <= acc_d;
            idx_q         <= idx_d;
            mult_output_q <= mult_output_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
`ifdef SYN_MAC_SATURATE_EN
            sat_q         <= sat_d;
            sat_flag_q    <= sat_flag_d;
`endif
        end
    end

    assign mult_output = mult_output_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;
`ifdef SYN_MAC_SATURATE_EN
    assign sat         = sat_q;
`else
    assign sat         = 1'b0;
`endif

endmodule

// File: tb/tb_syn_mac_acc.sv
// tb_syn_mac_acc: randomized and directed checks of syn_mac_acc against a
// behavioural model that sums spiked weights with plain integer arithmetic.
// A second small instance (8-bit weights and accumulator) covers overflow.
module tb_syn_mac_acc;

    localparam int N    = 8;
    localparam int AW   = 12;
    localparam int WW   = 16;
    localparam int ACCW = 20;
`ifdef SYN_MAC_SATURATE_EN
    localparam bit SAT_MODE = 1'b1;
`else
    localparam bit SAT_MODE = 1'b0;
`endif

    logic            CLK_Mac;
    logic            RST_n;

    logic            cfg_we;
    logic [2:0]      cfg_idx;
    logic [AW-1:0]   cfg_addr;
    logic [WW-1:0]   cfg_weight;
    logic            spike_valid;
    logic [AW-1:0]   spike_addr;
    logic            timestep;
    logic [ACCW-1:0] mult_output;
    logic            done, busy, overrun, sat;

    logic            o_cfg_we;
    logic [2:0]      o_cfg_idx;
    logic [AW-1:0]   o_cfg_addr;
    logic [7:0]      o_cfg_weight;
    logic            o_spike_valid;
    logic [AW-1:0]   o_spike_addr;
    logic            o_timestep;
    logic [7:0]      o_mult_output;
    logic            o_done, o_busy, o_overrun, o_sat;

    int errors = 0;
    int checks = 0;

    // Reference model state: table, captured spikes, pending result.
    bit              m_valid    [N];
    int              m_addr     [N];
    int              m_weight   [N];
    bit              m_incoming [N];
    int              m_cnt;
    logic [ACCW-1:0] m_pending;
    bit              m_pend_sat;
    logic [ACCW-1:0] exp_mult;
    bit              exp_done, exp_busy, exp_overrun, exp_sat;

    syn_mac_acc #(.NUM_CONN(N), .ADDR_W(AW), .WEIGHT_W(WW), .ACC_W(ACCW)) dut (
        .CLK_Mac(CLK_Mac), .RST_n(RST_n),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_weight(cfg_weight),
        .spike_valid(spike_valid), .spike_addr(spike_addr), .timestep(timestep),
        .mult_output(mult_output), .done(done), .busy(busy), .overrun(overrun), .sat(sat)
    );

    syn_mac_acc #(.NUM_CONN(N), .ADDR_W(AW), .WEIGHT_W(8), .ACC_W(8)) dut_ovf (
        .CLK_Mac(CLK_Mac), .RST_n(RST_n),
        .cfg_we(o_cfg_we), .cfg_idx(o_cfg_idx), .cfg_addr(o_cfg_addr), .cfg_weight(o_cfg_weight),
        .spike_valid(o_spike_valid), .spike_addr(o_spike_addr), .timestep(o_timestep),
        .mult_output(o_mult_output), .done(o_done), .busy(o_busy), .overrun(o_overrun), .sat(o_sat)
    );

    // Free-running clock.
    initial begin
        CLK_Mac = 1'b0;
        forever #5 CLK_Mac = ~CLK_Mac;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < N; i++) begin
            m_valid[i]    = 1'b0;
            m_addr[i]     = 0;
            m_weight[i]   = 0;
            m_incoming[i] = 1'b0;
        end
        m_cnt = 0; m_pending = '0; m_pend_sat = 1'b0;
        exp_mult = '0; exp_done = 1'b0; exp_busy = 1'b0; exp_overrun = 1'b0; exp_sat = 1'b0;
    endtask

    // Sum of the spiked weights in table order, clamping each step when saturating.
    function automatic logic [ACCW-1:0] sumSpiked(input bit [N-1:0] spk, output bit clamped);
        longint acc  = 0;
        longint maxv = (longint'(1) << (ACCW-1)) - 1;
        longint minv = -(longint'(1) << (ACCW-1));
        clamped = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (spk[i]) begin
                acc += m_weight[i];
                if (SAT_MODE && acc > maxv) begin acc = maxv; clamped = 1'b1; end
                if (SAT_MODE && acc < minv) begin acc = minv; clamped = 1'b1; end
            end
        end
        return ACCW'(acc);
    endfunction

    // Advance the model by one clock edge with the given inputs.
    task automatic modelStep(input bit we, input int idx, input int addr, input int w,
                             input bit sv, input int sa, input bit ts);
        bit [N-1:0]     spk;
        bit             was_busy, took, cl;
        logic signed [WW-1:0] wt;
        was_busy = (m_cnt > 0);
        took = 1'b0;
        exp_done = 1'b0; exp_overrun = 1'b0; exp_sat = 1'b0;
        if (was_busy) begin
            if (ts) exp_overrun = 1'b1;
            m_cnt--;
            if (m_cnt == 0) begin
                exp_done = 1'b1; exp_mult = m_pending; exp_sat = m_pend_sat;
            end
        end else if (ts) begin
            took = 1'b1;
            for (int i = 0; i < N; i++) begin
                spk[i] = m_incoming[i];
                m_incoming[i] = 1'b0;
            end
        end
        for (int i = 0; i < N; i++)
            if (sv && m_valid[i] && m_addr[i] == sa) m_incoming[i] = 1'b1;
        if (we && !was_busy && idx < N) begin
            wt = WW'(w);
            m_valid[idx] = 1'b1; m_addr[idx] = addr; m_weight[idx] = wt; m_incoming[idx] = 1'b0;
        end
        if (took) begin
            m_pending = sumSpiked(spk, cl);
            m_pend_sat = cl;
            m_cnt = N;
        end
        exp_busy = (m_cnt > 0);
    endtask

    // Drive one cycle of inputs, step the model, then compare every output.
    task automatic applyStimulus(input string tag, input bit we, input int idx, input int addr,
                                 input int w, input bit sv, input int sa, input bit ts);
        cfg_we = we; cfg_idx = 3'(idx); cfg_addr = AW'(addr); cfg_weight = WW'(w);
        spike_valid = sv; spike_addr = AW'(sa); timestep = ts;
        modelStep(we, idx, addr, w, sv, sa, ts);
        @(posedge CLK_Mac); #1;
        checkOutput({tag, ".mult"},    32'(mult_output), 32'(exp_mult));
        checkOutput({tag, ".done"},    32'(done),        32'(exp_done));
        checkOutput({tag, ".busy"},    32'(busy),        32'(exp_busy));
        checkOutput({tag, ".overrun"}, 32'(overrun),     32'(exp_overrun));
        checkOutput({tag, ".sat"},     32'(sat),         32'(exp_sat));
    endtask

    task automatic idleCycles(input string tag, input int n);
        for (int i = 0; i < n; i++) applyStimulus(tag, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic spike(input string tag, input int sa);
        applyStimulus(tag, 0, 0, 0, 0, 1, sa, 0);
    endtask

    // A timestep (optionally with a coincident spike), then N cycles to the done pulse.
    task automatic runTimestep(input string tag, input bit sv, input int sa, input int expected);
        applyStimulus(tag, 0, 0, 0, 0, sv, sa, 1);
        idleCycles(tag, N);
        checkOutput({tag, ".sum_const"},  32'(mult_output), 32'(expected));
        checkOutput({tag, ".done_const"}, 32'(done),        32'd1);
    endtask

    task automatic ovfCycle(input bit we, input int idx, input int addr, input int w,
                            input bit sv, input int sa, input bit ts);
        o_cfg_we = we; o_cfg_idx = 3'(idx); o_cfg_addr = AW'(addr); o_cfg_weight = 8'(w);
        o_spike_valid = sv; o_spike_addr = AW'(sa); o_timestep = ts;
        @(posedge CLK_Mac); #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, ".mult"},    32'(mult_output), 32'd0);
        checkOutput({tag, ".done"},    32'(done),        32'd0);
        checkOutput({tag, ".busy"},    32'(busy),        32'd0);
        checkOutput({tag, ".overrun"}, 32'(overrun),     32'd0);
        checkOutput({tag, ".sat"},     32'(sat),         32'd0);
    endtask

    // Main test sequence.
    initial begin
        bit seen;
        cfg_we = 0; cfg_idx = 0; cfg_addr = 0; cfg_weight = 0;
        spike_valid = 0; spike_addr = 0; timestep = 0;
        o_cfg_we = 0; o_cfg_idx = 0; o_cfg_addr = 0; o_cfg_weight = 0;
        o_spike_valid = 0; o_spike_addr = 0; o_timestep = 0;
        modelReset();
        RST_n = 1'b0;
        repeat (3) @(posedge CLK_Mac);
        #1;
        checkResetOutputs("reset");
        @(negedge CLK_Mac);
        RST_n = 1'b1;

        // Overflow on the narrow instance.
        ovfCycle(1, 0, 3, 100, 0, 0, 0);
        ovfCycle(1, 1, 4, 100, 0, 0, 0);
        ovfCycle(0, 0, 0, 0, 1, 3, 0);
        ovfCycle(0, 0, 0, 0, 1, 4, 0);
        ovfCycle(0, 0, 0, 0, 0, 0, 1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            ovfCycle(0, 0, 0, 0, 0, 0, 0);
            if (o_done) seen = 1'b1;
        end
        checkOutput("ovf.done_seen", 32'(seen), 32'd1);
        if (SAT_MODE) begin
            checkOutput("ovf.sum", 32'(o_mult_output), 32'h7F);
            checkOutput("ovf.sat", 32'(o_sat), 32'd1);
        end else begin
            checkOutput("ovf.sum", 32'(o_mult_output), 32'hC8);
            checkOutput("ovf.sat", 32'(o_sat), 32'd0);
        end

        // Basic sum.
        applyStimulus("cfg", 1, 0, 0, 10, 0, 0, 0);
        applyStimulus("cfg", 1, 1, 1, 20, 0, 0, 0);
        applyStimulus("cfg", 1, 2, 2, -5, 0, 0, 0);
        applyStimulus("cfg", 1, 3, 7, 100, 0, 0, 0);
        spike("basic", 0);
        spike("basic", 2);
        runTimestep("basic", 0, 0, 5);

        // Duplicates, unmatched address, empty timestep.
        spike("dup", 1); spike("dup", 1); spike("dup", 1); spike("dup", 9);
        runTimestep("dup", 0, 0, 20);
        runTimestep("empty", 0, 0, 0);

        // Spike coincident with timestep counts next time.
        runTimestep("coinc", 1, 7, 0);
        runTimestep("coinc_next", 0, 0, 100);

        // Overrun and a write attempt while busy.
        spike("ovr", 0);
        applyStimulus("ovr", 0, 0, 0, 0, 0, 0, 1);
        idleCycles("ovr", 1);
        applyStimulus("ovr", 1, 0, 0, 999, 0, 0, 0);
        applyStimulus("ovr", 0, 0, 0, 0, 0, 0, 1);
        checkOutput("ovr.overrun_const", 32'(overrun), 32'd1);
        idleCycles("ovr", N - 3);
        checkOutput("ovr.sum_const", 32'(mult_output), 32'd10);
        checkOutput("ovr.done_const", 32'(done), 32'd1);
        idleCycles("ovr_tail", 4);
        spike("after_ovr", 0);
        runTimestep("after_ovr", 0, 0, 10);

        // Randomized traffic.
        for (int c = 0; c < 800; c++) begin
            applyStimulus("rand",
                          ($urandom_range(0, 9) == 0), $urandom_range(0, N-1), $urandom_range(0, 15),
                          int'($urandom), $urandom_range(0, 1), $urandom_range(0, 15),
                          ($urandom_range(0, 7) == 0));
        end
        idleCycles("drain", N + 2);

        // Reset in the middle of an accumulation.
        applyStimulus("mid_rst", 1, 0, 0, 33, 0, 0, 0);
        spike("mid_rst", 0);
        applyStimulus("mid_rst", 0, 0, 0, 0, 0, 0, 1);
        idleCycles("mid_rst", 3);
        #2;
        RST_n = 1'b0;
        #1;
        checkResetOutputs("mid_rst.async");
        modelReset();
        @(negedge CLK_Mac);
        RST_n = 1'b1;
        idleCycles("post_rst", N + 4);
        spike("post_rst", 0);
        runTimestep("post_rst", 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
